// File: rtl/maze_pose_navigator_if.sv
// maze_pose_navigator_if
// Bundles the detector-facing inputs and the pose/status outputs of the maze
// pose navigator so the block can be wired with a single port.
//   master : drives frame timing, enable, side flags and side centres;
//            observes pose and status
//   slave  : the navigator itself
// Signals:
//   video_frame_valid      high during the active part of a frame
//   mazeParametersDefined  enables navigation; low forces a reload of the start pose
//   states                 {bottom, left, up, right}, 1 = side open
//   *_center               centroid offsets within each side window
//   curPose                [9:0]=v, [19:10]=h, [21:20]=heading, [25:22]=0
//   pose_update            one-cycle pulse after each committed step
//   done / stuck           sticky goal / blocked-or-out-of-budget flags
//   step_count             saturating count of committed steps
//   fsm_state              debug view of the controller state
interface maze_pose_navigator_if;
    logic        video_frame_valid;
    logic        mazeParametersDefined;
    logic [3:0]  states;
    logic [9:0]  bottom_center;
    logic [9:0]  left_center;
    logic [9:0]  upper_center;
    logic [9:0]  right_center;
    logic [25:0] curPose;
    logic        pose_update;
    logic        done;
    logic        stuck;
    logic [15:0] step_count;
    logic [2:0]  fsm_state;

    modport master (
        output video_frame_valid, mazeParametersDefined, states,
               bottom_center, left_center, upper_center, right_center,
        input  curPose, pose_update, done, stuck, step_count, fsm_state
    );

    modport slave (
        input  video_frame_valid, mazeParametersDefined, states,
               bottom_center, left_center, upper_center, right_center,
        output curPose, pose_update, done, stuck, step_count, fsm_state
    );
endinterface

// File: rtl/maze_pose_navigator.sv
// maze_pose_navigator
// Closed-loop pose generator for the maze path finder. Each frame it latches
// the detector's side flags and centres, chooses the next heading with the
// right-hand wall-following rule, re-centres the pose laterally and advances
// it by STEP pixels during vertical blanking. It stops when the goal window
// is reached, when boxed in, or when the step budget runs out.
// Ports:
//   clk  pixel clock
//   rst  asynchronous reset, active-high
//   bus  maze_pose_navigator_if.slave (inputs from detector/host, pose/status out)
module maze_pose_navigator #(
    parameter int          CENTER_V  = 8,
    parameter int          CENTER_H  = 15,
    parameter int          STEP      = 4,
    parameter int          START_H   = 20,
    parameter int          START_V   = 20,
    parameter int          START_DIR = 0,
    parameter int          GOAL_H    = 600,
    parameter int          GOAL_V    = 460,
    parameter int          GOAL_TOL  = 4,
    parameter int          H_MIN     = 16,
    parameter int          H_MAX     = 623,
    parameter int          V_MIN     = 9,
    parameter int          V_MAX     = 470,
    parameter logic [15:0] MAX_STEPS = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    maze_pose_navigator_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_FRAME  = 3'd2,
        S_DECIDE = 3'd3,
        S_UPDATE = 3'd4,
        S_DONE   = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [9:0] START_H_C   = 10'(START_H);
    localparam logic [9:0] START_V_C   = 10'(START_V);
    localparam logic [1:0] START_DIR_C = 2'(START_DIR);
    localparam logic [9:0] H_WIN_C     = 10'(2 * CENTER_H);
    localparam logic [9:0] V_WIN_C     = 10'(2 * CENTER_V);

    localparam logic signed [10:0] CENTER_H_S = 11'(CENTER_H);
    localparam logic signed [10:0] CENTER_V_S = 11'(CENTER_V);
    localparam logic signed [10:0] STEP_S     = 11'(STEP);
    localparam logic signed [10:0] H_MIN_S    = 11'(H_MIN);
    localparam logic signed [10:0] H_MAX_S    = 11'(H_MAX);
    localparam logic signed [10:0] V_MIN_S    = 11'(V_MIN);
    localparam logic signed [10:0] V_MAX_S    = 11'(V_MAX);
    localparam logic signed [10:0] GOAL_H_S   = 11'(GOAL_H);
    localparam logic signed [10:0] GOAL_V_S   = 11'(GOAL_V);
    localparam logic signed [10:0] GOAL_TOL_S = 11'(GOAL_TOL);

    state_t      state_q, state_d;
    logic        frame_valid_q, frame_valid_d;
    logic [3:0]  snap_states_q, snap_states_d;
    logic [9:0]  snap_bottom_q, snap_bottom_d;
    logic [9:0]  snap_left_q, snap_left_d;
    logic [9:0]  snap_upper_q, snap_upper_d;
    logic [9:0]  snap_right_q, snap_right_d;
    logic [9:0]  pose_h_q, pose_h_d;
    logic [9:0]  pose_v_q, pose_v_d;
    logic [1:0]  heading_q, heading_d;
    logic [9:0]  next_h_q, next_h_d;
    logic [9:0]  next_v_q, next_v_d;
    logic [1:0]  next_dir_q, next_dir_d;
    logic        next_goal_q, next_goal_d;
    logic [15:0] step_count_q, step_count_d;
    logic        pose_update_q, pose_update_d;
    logic        done_q, done_d;
    logic        stuck_q, stuck_d;

    logic [3:0]         open_dir;
    logic [1:0]         dir_right, dir_left, dir_back, dir_sel;
    logic               any_open;
    logic signed [10:0] h_s, v_s, dh, dv;
    logic               goal_hit;
    logic [15:0]        step_inc;

    // Heading choice and candidate pose, both derived from the latched
    // snapshot so blanking-time detector values never leak in. open_dir is
    // indexed by heading code (0=down, 1=left, 2=up, 3=right).
    always_comb begin
        open_dir  = {snap_states_q[0], snap_states_q[1], snap_states_q[2], snap_states_q[3]};
        any_open  = |open_dir;
        dir_right = heading_q + 2'd1;
        dir_left  = heading_q + 2'd3;
        dir_back  = heading_q + 2'd2;

        if (open_dir[dir_right]) begin
            dir_sel = dir_right;
        end else if (open_dir[heading_q]) begin
            dir_sel = heading_q;
        end else if (open_dir[dir_left]) begin
            dir_sel = dir_left;
        end else begin
            dir_sel = dir_back;
        end

        // A centre outside the side window means the detector saw nothing
        // usable, so the lateral coordinate is left alone in that case.
        h_s = $signed({1'b0, pose_h_q});
        v_s = $signed({1'b0, pose_v_q});
        case (dir_sel)
            2'd0: begin
                if (snap_bottom_q <= H_WIN_C) begin
                    h_s = h_s - CENTER_H_S + $signed({1'b0, snap_bottom_q});
                end
                v_s = v_s + STEP_S;
            end
            2'd1: begin
                if (snap_left_q <= V_WIN_C) begin
                    v_s = v_s - CENTER_V_S + $signed({1'b0, snap_left_q});
                end
                h_s = h_s - STEP_S;
            end
            2'd2: begin
                if (snap_upper_q <= H_WIN_C) begin
                    h_s = h_s - CENTER_H_S + $signed({1'b0, snap_upper_q});
                end
                v_s = v_s - STEP_S;
            end
            default: begin
                if (snap_right_q <= V_WIN_C) begin
                    v_s = v_s - CENTER_V_S + $signed({1'b0, snap_right_q});
                end
                h_s = h_s + STEP_S;
            end
        endcase

        if (h_s < H_MIN_S) begin
            h_s = H_MIN_S;
        end else if (h_s > H_MAX_S) begin
            h_s = H_MAX_S;
        end
        if (v_s < V_MIN_S) begin
            v_s = V_MIN_S;
        end else if (v_s > V_MAX_S) begin
            v_s = V_MAX_S;
        end

        dh       = h_s - GOAL_H_S;
        dv       = v_s - GOAL_V_S;
        goal_hit = (dh <= GOAL_TOL_S) && (dh >= -GOAL_TOL_S) &&
                   (dv <= GOAL_TOL_S) && (dv >= -GOAL_TOL_S);

        step_inc = (step_count_q == 16'hFFFF) ? step_count_q : step_count_q + 16'd1;
    end

    // Controller next-state logic. The snapshot tracks the inputs on every
    // in-frame cycle; the new pose is computed in DECIDE and only committed in
    // UPDATE, so a frame restarting during DECIDE simply throws the step away.
    always_comb begin
        state_d       = state_q;
        frame_valid_d = bus.video_frame_valid;
        snap_states_d = snap_states_q;
        snap_bottom_d = snap_bottom_q;
        snap_left_d   = snap_left_q;
        snap_upper_d  = snap_upper_q;
        snap_right_d  = snap_right_q;
        pose_h_d      = pose_h_q;
        pose_v_d      = pose_v_q;
        heading_d     = heading_q;
        next_h_d      = next_h_q;
        next_v_d      = next_v_q;
        next_dir_d    = next_dir_q;
        next_goal_d   = next_goal_q;
        step_count_d  = step_count_q;
        pose_update_d = 1'b0;
        done_d        = done_q;
        stuck_d       = stuck_q;

        if (bus.video_frame_valid) begin
            snap_states_d = bus.states;
            snap_bottom_d = bus.bottom_center;
            snap_left_d   = bus.left_center;
            snap_upper_d  = bus.upper_center;
            snap_right_d  = bus.right_center;
        end

        if (!bus.mazeParametersDefined) begin
            state_d      = S_IDLE;
            pose_h_d     = START_H_C;
            pose_v_d     = START_V_C;
            heading_d    = START_DIR_C;
            step_count_d = 16'd0;
            done_d       = 1'b0;
            stuck_d      = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    pose_h_d     = START_H_C;
                    pose_v_d     = START_V_C;
                    heading_d    = START_DIR_C;
                    step_count_d = 16'd0;
                    done_d       = 1'b0;
                    stuck_d      = 1'b0;
                    state_d      = S_WAIT;
                end
                S_WAIT: begin
                    if (bus.video_frame_valid) begin
                        state_d = S_FRAME;
                    end
                end
                S_FRAME: begin
                    if (frame_valid_q && !bus.video_frame_valid) begin
                        state_d = S_DECIDE;
                    end
                end
                S_DECIDE: begin
                    if (bus.video_frame_valid) begin
                        state_d = S_FRAME;
                    end else if (!any_open) begin
                        stuck_d = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        next_h_d    = h_s[9:0];
                        next_v_d    = v_s[9:0];
                        next_dir_d  = dir_sel;
                        next_goal_d = goal_hit;
                        state_d     = S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    pose_h_d      = next_h_q;
                    pose_v_d      = next_v_q;
                    heading_d     = next_dir_q;
                    step_count_d  = step_inc;
                    pose_update_d = 1'b1;
                    if (next_goal_q) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (step_inc == MAX_STEPS) begin
                        stuck_d = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_DONE: begin
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_HALT;
                end
            endcase
        end
    end

    // All controller and datapath state lives in this one register bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            frame_valid_q <= 1'b0;
            snap_states_q <= 4'd0;
            snap_bottom_q <= 10'd0;
            snap_left_q   <= 10'd0;
            snap_upper_q  <= 10'd0;
            snap_right_q  <= 10'd0;
            pose_h_q      <= START_H_C;
            pose_v_q      <= START_V_C;
            heading_q     <= START_DIR_C;
            next_h_q      <= START_H_C;
            next_v_q      <= START_V_C;
            next_dir_q    <= START_DIR_C;
            next_goal_q   <= 1'b0;
            step_count_q  <= 16'd0;
            pose_update_q <= 1'b0;
            done_q        <= 1'b0;
            stuck_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_valid_q <= frame_valid_d;
            snap_states_q <= snap_states_d;
            snap_bottom_q <= snap_bottom_d;
            snap_left_q   <= snap_left_d;
            snap_upper_q  <= snap_upper_d;
            snap_right_q  <= snap_right_d;
            pose_h_q      <= pose_h_d;
            pose_v_q      <= pose_v_d;
            heading_q     <= heading_d;
            next_h_q      <= next_h_d;
            next_v_q      <= next_v_d;
            next_dir_q    <= next_dir_d;
            next_goal_q   <= next_goal_d;
            step_count_q  <= step_count_d;
            pose_update_q <= pose_update_d;
            done_q        <= done_d;
            stuck_q       <= stuck_d;
        end
    end

    assign bus.curPose     = {4'b0000, heading_q, pose_h_q, pose_v_q};
    assign bus.pose_update = pose_update_q;
    assign bus.done        = done_q;
    assign bus.stuck       = stuck_q;
    assign bus.step_count  = step_count_q;
    assign bus.fsm_state   = state_q;

endmodule

// File: tb/tb_maze_pose_navigator.sv
// tb_maze_pose_navigator
// Directed bench for maze_pose_navigator. Three instances share one stimulus:
//   dut_a  default parameters: corridor, turn priority, clamping, blocking,
//          enable drop and reset behaviour
//   dut_b  starts at (100,10) heading up with a step budget of 2: lateral
//          correction, clamping of v and the budget stop
//   dut_c  starts just short of the goal: goal detection and hold
module tb_maze_pose_navigator;

    logic       clk = 1'b0;
    logic       rst;
    logic       vfv;
    logic       mpd;
    logic [3:0] st;
    logic [9:0] bc, lc, uc, rc;

    int checks = 0;
    int errors = 0;

    maze_pose_navigator_if if_a ();
    maze_pose_navigator_if if_b ();
    maze_pose_navigator_if if_c ();

    assign if_a.video_frame_valid     = vfv;
    assign if_a.mazeParametersDefined = mpd;
    assign if_a.states                = st;
    assign if_a.bottom_center         = bc;
    assign if_a.left_center           = lc;
    assign if_a.upper_center          = uc;
    assign if_a.right_center          = rc;

    assign if_b.video_frame_valid     = vfv;
    assign if_b.mazeParametersDefined = mpd;
    assign if_b.states                = st;
    assign if_b.bottom_center         = bc;
    assign if_b.left_center           = lc;
    assign if_b.upper_center          = uc;
    assign if_b.right_center          = rc;

    assign if_c.video_frame_valid     = vfv;
    assign if_c.mazeParametersDefined = mpd;
    assign if_c.states                = st;
    assign if_c.bottom_center         = bc;
    assign if_c.left_center           = lc;
    assign if_c.upper_center          = uc;
    assign if_c.right_center          = rc;

    maze_pose_navigator dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));

    maze_pose_navigator #(
        .START_H(100), .START_V(10), .START_DIR(2), .MAX_STEPS(16'd2)
    ) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

    maze_pose_navigator #(
        .START_H(600), .START_V(454), .START_DIR(0)
    ) dut_c (.clk(clk), .rst(rst), .bus(if_c.slave));

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        logic [9:0] b, l, u, r;
        int         exp_h;
        int         exp_v;
        int         exp_dir;
    } vec_t;

    vec_t vecs[10];

    function automatic logic [31:0] pose(input int h, input int v, input int d);
        logic [25:0] p;
        p = {4'b0000, 2'(d), 10'(h), 10'(v)};
        return {6'd0, p};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // One frame: four in-frame cycles with the given detector values, then
    // blanking with junk on the detector lines so a snapshot taken outside
    // the frame would steer the pose somewhere visibly wrong (or block it).
    // Returns #1 after the last in-frame edge.
    task automatic applyStimulus(input logic [3:0] s, input logic [9:0] b,
                                 input logic [9:0] l, input logic [9:0] u,
                                 input logic [9:0] r);
        @(posedge clk);
        #1;
        st  = s;
        bc  = b;
        lc  = l;
        uc  = u;
        rc  = r;
        vfv = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        vfv = 1'b0;
        st  = 4'b0000;
        bc  = 10'h3FF;
        lc  = 10'h3FF;
        uc  = 10'h3FF;
        rc  = 10'h3FF;
    endtask

    initial begin
        rst = 1'b1;
        vfv = 1'b0;
        mpd = 1'b0;
        st  = 4'b0000;
        bc  = 10'd0;
        lc  = 10'd0;
        uc  = 10'd0;
        rc  = 10'd0;

        vecs[0] = '{4'b1010, 10'd15, 10'd8,  10'd15, 10'd8, 20, 28, 0};
        vecs[1] = '{4'b1010, 10'd15, 10'd8,  10'd15, 10'd8, 20, 32, 0};
        vecs[2] = '{4'b1111, 10'd15, 10'd8,  10'd15, 10'd8, 16, 32, 1};
        vecs[3] = '{4'b0001, 10'd15, 10'd8,  10'd15, 10'd8, 20, 32, 3};
        vecs[4] = '{4'b0100, 10'd15, 10'd12, 10'd15, 10'd8, 16, 36, 1};
        vecs[5] = '{4'b0100, 10'd15, 10'd16, 10'd15, 10'd8, 16, 44, 1};
        vecs[6] = '{4'b0100, 10'd15, 10'd17, 10'd15, 10'd8, 16, 44, 1};
        vecs[7] = '{4'b1000, 10'd30, 10'd8,  10'd15, 10'd8, 31, 48, 0};
        vecs[8] = '{4'b1000, 10'd31, 10'd8,  10'd15, 10'd8, 31, 52, 0};
        vecs[9] = '{4'b0001, 10'd15, 10'd8,  10'd15, 10'd0, 35, 44, 3};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_pose_a", {6'd0, if_a.curPose}, pose(20, 20, 0));
        checkOutput("reset_pose_b", {6'd0, if_b.curPose}, pose(100, 10, 2));
        checkOutput("reset_pulse", {31'd0, if_a.pose_update}, 32'd0);
        checkOutput("reset_done", {31'd0, if_a.done}, 32'd0);
        checkOutput("reset_stuck", {31'd0, if_a.stuck}, 32'd0);
        checkOutput("reset_steps", {16'd0, if_a.step_count}, 32'd0);
        checkOutput("reset_state", {29'd0, if_a.fsm_state}, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        mpd = 1'b1;

        // First corridor frame with cycle-exact latency checks
        applyStimulus(4'b1010, 10'd15, 10'd8, 10'd15, 10'd8);
        checkOutput("inframe_pose_frozen", {6'd0, if_a.curPose}, pose(20, 20, 0));
        @(posedge clk);
        #1;
        checkOutput("e0_state_decide", {29'd0, if_a.fsm_state}, 32'd3);
        @(posedge clk);
        #1;
        checkOutput("e1_state_update", {29'd0, if_a.fsm_state}, 32'd4);
        checkOutput("e1_pose_old", {6'd0, if_a.curPose}, pose(20, 20, 0));
        checkOutput("e1_pulse_low", {31'd0, if_a.pose_update}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("e2_pose_new", {6'd0, if_a.curPose}, pose(20, 24, 0));
        checkOutput("e2_pulse_high", {31'd0, if_a.pose_update}, 32'd1);
        checkOutput("e2_state_wait", {29'd0, if_a.fsm_state}, 32'd1);
        checkOutput("e2_steps", {16'd0, if_a.step_count}, 32'd1);
        checkOutput("goal_done_c", {31'd0, if_c.done}, 32'd1);
        checkOutput("goal_pose_c", {6'd0, if_c.curPose}, pose(600, 458, 0));
        checkOutput("goal_state_c", {29'd0, if_c.fsm_state}, 32'd5);
        @(posedge clk);
        #1;
        checkOutput("e3_pulse_low", {31'd0, if_a.pose_update}, 32'd0);

        // Table of single-frame moves for dut_a
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].st, vecs[i].b, vecs[i].l, vecs[i].u, vecs[i].r);
            repeat (3) @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_pose", i), {6'd0, if_a.curPose},
                        pose(vecs[i].exp_h, vecs[i].exp_v, vecs[i].exp_dir));
            checkOutput($sformatf("vec%0d_pulse", i), {31'd0, if_a.pose_update}, 32'd1);
        end
        checkOutput("table_steps", {16'd0, if_a.step_count}, 32'd11);
        checkOutput("goal_hold_pose_c", {6'd0, if_c.curPose}, pose(600, 458, 0));
        checkOutput("goal_hold_done_c", {31'd0, if_c.done}, 32'd1);
        checkOutput("budget_stuck_b", {31'd0, if_b.stuck}, 32'd1);
        checkOutput("budget_steps_b", {16'd0, if_b.step_count}, 32'd2);
        checkOutput("budget_state_b", {29'd0, if_b.fsm_state}, 32'd6);

        // Boxed in: stuck, HALT, pose frozen on later frames
        applyStimulus(4'b0000, 10'd15, 10'd8, 10'd15, 10'd8);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("blocked_stuck", {31'd0, if_a.stuck}, 32'd1);
        checkOutput("blocked_state", {29'd0, if_a.fsm_state}, 32'd6);
        checkOutput("blocked_pulse", {31'd0, if_a.pose_update}, 32'd0);
        applyStimulus(4'b1010, 10'd15, 10'd8, 10'd15, 10'd8);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("halt_pose_frozen", {6'd0, if_a.curPose}, pose(35, 44, 3));
        checkOutput("halt_steps", {16'd0, if_a.step_count}, 32'd11);

        // Dropping the enable reloads the start pose and clears flags
        mpd = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mpd_state_idle", {29'd0, if_a.fsm_state}, 32'd0);
        checkOutput("mpd_pose_reload", {6'd0, if_a.curPose}, pose(20, 20, 0));
        checkOutput("mpd_stuck_clear", {31'd0, if_a.stuck}, 32'd0);
        checkOutput("mpd_steps_clear", {16'd0, if_a.step_count}, 32'd0);
        checkOutput("mpd_done_clear_c", {31'd0, if_c.done}, 32'd0);
        checkOutput("mpd_pose_reload_c", {6'd0, if_c.curPose}, pose(600, 454, 0));
        mpd = 1'b1;

        // Moving up with lateral correction, v clamped at V_MIN
        applyStimulus(4'b0010, 10'd15, 10'd8, 10'd20, 10'd8);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("lateral_pose_b", {6'd0, if_b.curPose}, pose(105, 9, 2));
        checkOutput("back_turn_pose_a", {6'd0, if_a.curPose}, pose(25, 16, 2));

        // Same move with a centre outside the window: h kept
        mpd = 1'b0;
        @(posedge clk);
        #1;
        mpd = 1'b1;
        applyStimulus(4'b0010, 10'd15, 10'd8, 10'd40, 10'd8);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("nocorr_pose_b", {6'd0, if_b.curPose}, pose(100, 9, 2));
        checkOutput("nocorr_pose_a", {6'd0, if_a.curPose}, pose(20, 16, 2));

        // Reset asserted while UPDATE is pending
        applyStimulus(4'b1010, 10'd15, 10'd8, 10'd15, 10'd8);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("pre_rst_state_update", {29'd0, if_a.fsm_state}, 32'd4);
        rst = 1'b1;
        #1;
        checkOutput("rst_pose", {6'd0, if_a.curPose}, pose(20, 20, 0));
        checkOutput("rst_state", {29'd0, if_a.fsm_state}, 32'd0);
        checkOutput("rst_steps", {16'd0, if_a.step_count}, 32'd0);
        checkOutput("rst_pulse", {31'd0, if_a.pose_update}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("post_rst_pose", {6'd0, if_a.curPose}, pose(20, 20, 0));
        checkOutput("post_rst_state_wait", {29'd0, if_a.fsm_state}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/maze_pose_navigator.md
# maze_pose_navigator

Closed-loop pose generator for the maze path finder. Owns `curPose`, which the geometric-centre detector consumes each frame. Once per video frame it latches the detector's four side flags and side centres, picks the next heading by the right-hand wall-following rule, and re-centres the pose laterally. It then advances the pose one step during vertical blanking and stops on reaching the goal or when boxed in.

## Interface
Parameters:
- `CENTER_V`, 8, half-height of the sampling box (must match detector)
- `CENTER_H`, 15, half-width of the sampling box (must match detector)
- `STEP`, 4, pixels advanced per frame
- `START_H` / `START_V` / `START_DIR`, 20 / 20 / 0, pose and heading loaded from IDLE
- `GOAL_H` / `GOAL_V` / `GOAL_TOL`, 600 / 460 / 4, goal window centre and half-size
- `H_MIN` / `H_MAX`, 16 / 623, clamp range for h
- `V_MIN` / `V_MAX`, 9 / 470, clamp range for v
- `MAX_STEPS`, 16'hFFFF, step budget

Ports:
- `clk`  in  1  pixel clock
- `rst`  in  1  asynchronous reset, active-high
- `video_frame_valid`  in  1  high during active frame
- `mazeParametersDefined`  in  1  enables navigation
- `states`  in  4  {bottom, left, up, right}; 1 = side open
- `bottom_center`, `left_center`, `upper_center`, `right_center`  in  10 each  centroid offsets within each side window
- `curPose`  out  26  [9:0]=v, [19:10]=h, [21:20]=heading, [25:22]=0
- `pose_update`  out  1  one-cycle pulse after each curPose change
- `done`  out  1  goal reached (sticky)
- `stuck`  out  1  no open side, or step budget exhausted (sticky)
- `step_count`  out  16  steps taken, saturating
- `fsm_state`  out  3  debug encoding of the current state

## Operation
- Heading encoding: 0 = down (+v), 1 = left (−h), 2 = up (−v), 3 = right (+h).
- Open flag of direction d: d0 = `states[3]`, d1 = `states[2]`, d2 = `states[1]`, d3 = `states[0]`.
- Snapshot: on every clk with `video_frame_valid` = 1, register `states` and the four centres. The detector clears its sums during blanking, so only in-frame values are valid.
- FSM states and transitions:
  - IDLE(0): load START pose and heading, clear `step_count`; go to WAIT when `mazeParametersDefined` = 1.
  - WAIT(1): go to FRAME on `video_frame_valid` = 1.
  - FRAME(2): on the falling edge of `video_frame_valid` (previous-cycle register = 1, current = 0), go to DECIDE.
  - DECIDE(3): pick the new heading from the snapshot using priority heading+1 (right turn), heading, heading+3 (left turn), heading+2 (back), all mod 4. If no side is open, set `stuck` and go to HALT; otherwise go to UPDATE.
  - UPDATE(4): write the new pose, increment `step_count`, pulse `pose_update` next cycle. Then go to DONE if inside the goal window, HALT if `step_count` = MAX_STEPS (set `stuck`), else WAIT.
  - DONE(5): hold, `done` = 1.
  - HALT(6): hold.
- Pose arithmetic (10-bit unsigned):
  - Moving down/up: h' = h − CENTER_H + c, with c = `bottom_center` (down) or `upper_center` (up).
  - Moving left/right: v' = v − CENTER_V + c, with c = `left_center` (left) or `right_center` (right).
  - The correction applies only if c ≤ 2·CENTER_H (vertical move) or c ≤ 2·CENTER_V (horizontal move); otherwise the coordinate is kept.
  - Then advance ±STEP along the heading.
  - Compute in 11-bit signed; clamp both coordinates to [MIN, MAX] after the advance.
- Goal window test: |h' − GOAL_H| ≤ GOAL_TOL and |v' − GOAL_V| ≤ GOAL_TOL.
- `mazeParametersDefined` = 0 in any state: go to IDLE next cycle (pose reloaded, `done`/`stuck` cleared).
- If `video_frame_valid` reasserts while in DECIDE, that step is discarded: pose unchanged, go to FRAME.

## Timing
- Reset values:
  - `curPose` = {4'b0, START_DIR, START_H, START_V}
  - `pose_update` = `done` = `stuck` = 0
  - `step_count` = 0
  - `fsm_state` = IDLE
- Let E be the first clk with `video_frame_valid` low after a frame. DECIDE runs at E+1 and UPDATE at E+2.
- New `curPose` is visible from E+3; `pose_update` is high during cycle E+3 only.
- `curPose` never changes while `video_frame_valid` = 1.
- Snapshot latency: the values used are those of the last in-frame cycle (E−1).
- `step_count` saturates at 16'hFFFF.

## Test plan
- Straight corridor: START (20,20), heading 0; per frame `states` = 4'b1010, `bottom_center` = 15. Required: h stays 20, v += 4 per frame, `pose_update` exactly at E+3.
- Right-hand priority: heading 0, `states` = 4'b1111. Required: new heading 1, h −= 4.
- Dead end: heading 3, `states` = 4'b0100 (left only, i.e. back). Required: heading 1.
- Blocked: `states` = 4'b0000. Required: `stuck` = 1, FSM in HALT, pose frozen for subsequent frames.
- Lateral correction and clamping: heading 2 at (h=100, v=10), `upper_center` = 20. Required: h = 105, v clamped to 9.
  - Same move with `upper_center` = 40: h unchanged at 100.
- Goal and controls:
  - Pose stepping to (600, 458): `done` = 1 and pose holds afterwards.
  - Asserting `rst` mid-UPDATE: immediate reset values.
  - Dropping `mazeParametersDefined`: IDLE, START pose reloaded.
